// File: rtl/melody_seq_writer_pkg.sv
// Shared types and constants for the melody sequence writer.
// State encoding is exposed on state_out, so the values are fixed.
package melody_seq_writer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_WRITE = 3'd2,
        S_WAIT  = 3'd3,
        S_START = 3'd4,
        S_PLAY  = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam int          SLOT_W    = 4;
    localparam int          NOTE_W    = 3;
    localparam int          MAX_NOTES = 8;

endpackage

// File: rtl/melody_seq_writer_lfsr.sv
// 16-bit right-shifting Galois LFSR that advances every cycle; a load takes effect next edge.
// Loading zero substitutes SEED so the register can never lock up at all-zero.
module lfsr16_galois
    import melody_seq_writer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
        if (load) begin
            lfsr_d = (load_val == 16'h0000) ? SEED : load_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/melody_seq_writer.sv
// Generates a pseudo-random melody, writes it to the game register, then starts the game.
// write_enable at T+NUM_NOTES+1, game_start START_DELAY+1 cycles later; requests ignored until game_end.
module melody_seq_writer
    import melody_seq_writer_pkg::*;
#(
    parameter int          NUM_NOTES   = 8,
    parameter int          START_DELAY = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter bit          NO_REPEAT   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          new_game_req,
    input  logic                          seed_load,
    input  logic [15:0]                   seed_in,
    input  logic                          game_end,
    output logic [SLOT_W*MAX_NOTES-1:0]   data_out,
    output logic                          write_enable,
    output logic                          game_start,
    output logic                          busy,
    output logic [3:0]                    note_count,
    output logic [2:0]                    state_out
);

    state_t                        state_q, state_d;
    logic [SLOT_W*MAX_NOTES-1:0]   data_q, data_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [3:0]                    delay_q, delay_d;
    logic [NOTE_W-1:0]             prev_q, prev_d;
    logic                          req_q;
    logic                          end_q;

    logic [15:0]                   lfsr_val;
    logic                          lfsr_load;
    logic                          req_rise;
    logic                          end_rise;
    logic [NOTE_W-1:0]             note_raw;
    logic [NOTE_W-1:0]             note_gen;
    logic [2:0]                    slot;

    // Upper LFSR bits only feed the register's own next state.
    logic                          lfsr_unused;
    assign lfsr_unused = ^lfsr_val[15:NOTE_W];

    assign lfsr_load = (state_q == S_IDLE) && seed_load;

    lfsr16_galois #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .load_val(seed_in),
        .value   (lfsr_val)
    );

    assign req_rise = new_game_req & ~req_q;
    assign end_rise = game_end & ~end_q;
    assign note_raw = lfsr_val[NOTE_W-1:0];
    assign slot     = cnt_q[2:0];

    always_comb begin
        note_gen = note_raw;
        if (NO_REPEAT && (cnt_q != 4'd0) && (note_raw == prev_q)) begin
            note_gen = note_raw + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                if (req_rise) begin
                    state_d = S_GEN;
                    data_d  = '0;
                    cnt_d   = 4'd0;
                    prev_d  = '0;
                end
            end
            S_GEN: begin
                data_d[SLOT_W*slot +: SLOT_W] = {1'b0, note_gen};
                prev_d = note_gen;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(NUM_NOTES - 1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_WAIT;
                delay_d = 4'(START_DELAY);
            end
            S_WAIT: begin
                if (delay_q <= 4'd1) begin
                    state_d = S_START;
                end else begin
                    delay_d = delay_q - 4'd1;
                end
            end
            S_START: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (end_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= 4'd0;
            delay_q <= 4'd0;
            prev_q  <= '0;
            req_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            prev_q  <= prev_d;
            req_q   <= new_game_req;
            end_q   <= game_end;
        end
    end

    assign data_out     = data_q;
    assign write_enable = (state_q == S_WRITE);
    assign game_start   = (state_q == S_START);
    assign busy         = (state_q != S_IDLE);
    assign note_count   = cnt_q;
    assign state_out    = state_q;

endmodule

// File: doc/melody_seq_writer.md
Name: melody_seq_writer

Overview:
- Producer side of the game module's sequence-load interface.
- Generates a pseudo-random melody of up to 8 notes and packs it into the 32-bit nibble format the game register expects: per slot, bits [2:0] hold the note and bit [3] is 0.
- Issues a one-cycle write_enable with the packed word, then a one-cycle game_start after a fixed delay.
- Then waits for the game's end indication before it accepts another request.

Parameters:
- NUM_NOTES, 8: notes generated, legal range 1..8. Slots at or above NUM_NOTES are written as 0.
- START_DELAY, 4: cycles spent in WAIT between the write_enable pulse and the game_start pulse. Legal range 1..15.
- LFSR_SEED, 16'hACE1: LFSR value after reset, and the substitute value when a zero seed is loaded.
- NO_REPEAT, 1: when 1, no two consecutive generated notes are equal.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- new_game_req, input, 1: synchronous level request. Only a rising edge counts.
- seed_load, input, 1: load seed_in into the LFSR. Honoured only in IDLE.
- seed_in, input, 16: seed value.
- game_end, input, 1: sticky end flag from the game module. Only a rising edge counts.
- data_out, output, 32: packed melody. Connects to the game's data_in.
- write_enable, output, 1: one-cycle load strobe.
- game_start, output, 1: one-cycle start strobe.
- busy, output, 1: high in every state except IDLE.
- note_count, output, 4: number of slots generated so far in the current load, 0..NUM_NOTES.
- state_out, output, 3: current state encoding, for debug.

Behaviour:
- Reset values:
  - state IDLE; LFSR = LFSR_SEED; data_out = 0.
  - write_enable, game_start and busy = 0; note_count = 0; state_out = 0.
  - Edge-detect history registers = 0.
  - Reset asserted mid-operation forces all of the above immediately. No pulse completes.
- LFSR:
  - 16-bit Galois, polynomial mask 16'hB400, shifts right.
  - Advances every cycle in every state, so the seed depends on when the user presses.
  - A load of 0 substitutes LFSR_SEED, so the LFSR never reaches the all-zero lock-up state.
- IDLE (0):
  - seed_load=1 loads the seed on the next clock edge.
  - A new_game_req rising edge moves to GEN, clears data_out and note_count, and clears the previous-note register.
  - If seed_load and the request edge arrive in the same cycle, the load wins for the LFSR value and GEN still starts the next cycle.
- GEN (1), lasts NUM_NOTES cycles, one slot k per cycle, k = note_count:
  - note = lfsr[2:0].
  - If NO_REPEAT, k>0 and note equals the previous note, use note+1 mod 8 (7 wraps to 0).
  - data_out[4k+2:4k] <= note and data_out[4k+3] <= 0; note_count increments.
  - After slot NUM_NOTES-1 is written, move to WRITE.
- WRITE (2):
  - write_enable=1 for exactly one cycle.
  - data_out is stable from this cycle until the next GEN.
  - Next state WAIT; the delay counter loads START_DELAY.
- WAIT (3): counts down START_DELAY cycles, then moves to START.
- START (4): game_start=1 for exactly one cycle, then moves to PLAY.
- PLAY (5): moves to IDLE on a game_end rising edge. game_end held high from a previous game does not retrigger.
- Request handling: new_game_req edges outside IDLE are ignored and not queued. seed_load outside IDLE is ignored.
- Latency, with the request edge sampled at cycle T:
  - GEN occupies T+1..T+NUM_NOTES.
  - write_enable is high at T+NUM_NOTES+1.
  - game_start is high at T+NUM_NOTES+2+START_DELAY.
  - With defaults: write_enable at T+9, game_start at T+14.
- write_enable and game_start are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE..PLAY, 3-bit);
  - the LFSR polynomial constant 16'hB400;
  - SLOT_W=4, NOTE_W=3 and MAX_NOTES=8.
- One sub-module: lfsr16_galois, with clk, reset, load, load_val and a 16-bit value output. It handles the zero-seed substitution internally.

Test Plan:
- Reset: hold reset=0 then release → all outputs 0, state_out=0, busy=0.
- Timing, defaults: seed_load with 16'h1234 in IDLE, then a new_game_req edge at T → write_enable high only at T+9, game_start high only at T+14.
  - data_out matches the bench LFSR model.
  - Every bit[4k+3] is 0.
  - No equal adjacent notes.
- Zero seed and short melody, NUM_NOTES=3: seed_load with seed_in=0 → generated notes match a model seeded with 16'hACE1; data_out[31:12]=0.
- Ignored requests: new_game_req toggled during WAIT and PLAY → no extra write_enable.
  - Raising game_end then returns to IDLE.
  - A later game_end that stays high does not retrigger a return from PLAY.
- Reset mid-sequence: drive reset=0 at T+5 → data_out=0 and busy=0 immediately.
  - After release, a new request produces a full sequence from LFSR_SEED.
- Simultaneous events: seed_load and a request edge in the same IDLE cycle → the sequence is generated from the newly loaded seed.
